// File: rtl/regfile_write_queue_if.sv
// Bundles the request, drain, register-file write and forwarding-lookup
// signals of the register-file write queue.
interface regfile_write_queue_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              in_valid;
   logic [ADDR_W-1:0] in_rd;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              drain_en;
   logic              wrt;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] dataIn;
   logic [ADDR_W-1:0] look_rs1;
   logic [ADDR_W-1:0] look_rs2;
   logic              hit1;
   logic              hit2;
   logic [DATA_W-1:0] fwd1;
   logic [DATA_W-1:0] fwd2;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;

   modport master (
      output in_valid, in_rd, in_data, drain_en, look_rs1, look_rs2,
      input  in_ready, wrt, rd, dataIn, hit1, hit2, fwd1, fwd2, count, full, empty
   );

   modport slave (
      input  in_valid, in_rd, in_data, drain_en, look_rs1, look_rs2,
      output in_ready, wrt, rd, dataIn, hit1, hit2, fwd1, fwd2, count, full, empty
   );
endinterface

// File: rtl/regfile_write_queue.sv
// In-order write queue feeding the register file's single write port.
// Define WRQ_FORWARD_EN to build the pending-write forwarding lookup.
module regfile_write_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   regfile_write_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] memRd   [DEPTH];
   logic [DATA_W-1:0] memData [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  cnt;
   logic              doPush;
   logic              doPop;

   // DEPTH need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign bus.count    = cnt;
   assign bus.full     = (cnt == CNT_W'(DEPTH));
   assign bus.empty    = (cnt == '0);
   assign bus.in_ready = !bus.full;
   assign doPush       = bus.in_valid && !bus.full;
   assign doPop        = !bus.empty && bus.drain_en;

   // Entry storage carries no reset; validity comes from head/count only.
   always_ff @(posedge clk) begin
      if (doPush) begin
         memRd[tail]   <= bus.in_rd;
         memData[tail] <= bus.in_data;
      end
   end

   // Pointers, occupancy and the registered write-port stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head       <= '0;
         tail       <= '0;
         cnt        <= '0;
         bus.wrt    <= 1'b0;
         bus.rd     <= '0;
         bus.dataIn <= '0;
      end else begin
         if (doPush) begin
            tail <= nextPtr(tail);
         end
         if (doPop) begin
            bus.wrt    <= 1'b1;
            bus.rd     <= memRd[head];
            bus.dataIn <= memData[head];
            head       <= nextPtr(head);
         end else begin
            bus.wrt <= 1'b0;
         end
         case ({doPush, doPop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

`ifdef WRQ_FORWARD_EN
   int               fwdSum;
   logic [PTR_W-1:0] fwdIdx;

   // Output stage is lowest priority; later (younger) queue hits overwrite.
   always_comb begin
      bus.hit1 = 1'b0;
      bus.fwd1 = '0;
      bus.hit2 = 1'b0;
      bus.fwd2 = '0;
      fwdSum   = 0;
      fwdIdx   = '0;
      if (bus.wrt && bus.rd == bus.look_rs1) begin
         bus.hit1 = 1'b1;
         bus.fwd1 = bus.dataIn;
      end
      if (bus.wrt && bus.rd == bus.look_rs2) begin
         bus.hit2 = 1'b1;
         bus.fwd2 = bus.dataIn;
      end
      for (int i = 0; i < DEPTH; i++) begin
         fwdSum = int'(head) + i;
         if (fwdSum >= DEPTH) begin
            fwdSum = fwdSum - DEPTH;
         end
         fwdIdx = PTR_W'(fwdSum);
         if (i < int'(cnt)) begin
            if (memRd[fwdIdx] == bus.look_rs1) begin
               bus.hit1 = 1'b1;
               bus.fwd1 = memData[fwdIdx];
            end
            if (memRd[fwdIdx] == bus.look_rs2) begin
               bus.hit2 = 1'b1;
               bus.fwd2 = memData[fwdIdx];
            end
         end
      end
   end
`else
   logic unusedLook;

   assign unusedLook = ^{bus.look_rs1, bus.look_rs2};
   assign bus.hit1   = 1'b0;
   assign bus.hit2   = 1'b0;
   assign bus.fwd1   = '0;
   assign bus.fwd2   = '0;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed, table-driven bench for regfile_write_queue (DEPTH=4), with a
// streaming push/pop sequence that walks the pointers through several wraps.
module tb_regfile_write_queue;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;
`ifdef WRQ_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct {
      string             name;
      bit                rstN;
      bit                inValid;
      logic [ADDR_W-1:0] inRd;
      logic [DATA_W-1:0] inData;
      bit                drainEn;
      logic [ADDR_W-1:0] look1;
      logic [ADDR_W-1:0] look2;
      bit                eWrt;
      logic [ADDR_W-1:0] eRd;
      logic [DATA_W-1:0] eData;
      int                eCount;
      bit                eHit1;
      logic [DATA_W-1:0] eFwd1;
      bit                eHit2;
      logic [DATA_W-1:0] eFwd2;
   } vec_t;

   logic   clk = 1'b0;
   logic   rst_n;
   int     passCount = 0;
   int     checkCount = 0;
   vec_t   vecs[$];

   regfile_write_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   regfile_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic void add(input string name, input bit rstN, input bit inValid,
                               input int inRd, input int inData, input bit drainEn,
                               input int look1, input int look2, input bit eWrt,
                               input int eRd, input int eData, input int eCount,
                               input bit eHit1, input int eFwd1, input bit eHit2,
                               input int eFwd2);
      vec_t v;
      v.name    = name;
      v.rstN    = rstN;
      v.inValid = inValid;
      v.inRd    = ADDR_W'(inRd);
      v.inData  = DATA_W'(inData);
      v.drainEn = drainEn;
      v.look1   = ADDR_W'(look1);
      v.look2   = ADDR_W'(look2);
      v.eWrt    = eWrt;
      v.eRd     = ADDR_W'(eRd);
      v.eData   = DATA_W'(eData);
      v.eCount  = eCount;
      v.eHit1   = FWD ? eHit1 : 1'b0;
      v.eFwd1   = FWD ? DATA_W'(eFwd1) : '0;
      v.eHit2   = FWD ? eHit2 : 1'b0;
      v.eFwd2   = FWD ? DATA_W'(eFwd2) : '0;
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
   task automatic applyStimulus(input bit rstN, input bit inValid, input logic [ADDR_W-1:0] inRd,
                                input logic [DATA_W-1:0] inData, input bit drainEn,
                                input logic [ADDR_W-1:0] look1, input logic [ADDR_W-1:0] look2);
      @(negedge clk);
      rst_n        = rstN;
      bus.in_valid = inValid;
      bus.in_rd    = inRd;
      bus.in_data  = inData;
      bus.drain_en = drainEn;
      bus.look_rs1 = look1;
      bus.look_rs2 = look2;
      @(posedge clk);
      #1;
   endtask

   task automatic checkVector(input vec_t v);
      checkOutput({v.name, ".wrt"},      32'(bus.wrt),      32'(v.eWrt));
      checkOutput({v.name, ".rd"},       32'(bus.rd),       32'(v.eRd));
      checkOutput({v.name, ".dataIn"},   bus.dataIn,        v.eData);
      checkOutput({v.name, ".count"},    32'(bus.count),    32'(v.eCount));
      checkOutput({v.name, ".full"},     32'(bus.full),     32'(v.eCount == DEPTH));
      checkOutput({v.name, ".empty"},    32'(bus.empty),    32'(v.eCount == 0));
      checkOutput({v.name, ".in_ready"}, 32'(bus.in_ready), 32'(v.eCount != DEPTH));
      checkOutput({v.name, ".hit1"},     32'(bus.hit1),     32'(v.eHit1));
      checkOutput({v.name, ".fwd1"},     bus.fwd1,          v.eFwd1);
      checkOutput({v.name, ".hit2"},     32'(bus.hit2),     32'(v.eHit2));
      checkOutput({v.name, ".fwd2"},     bus.fwd2,          v.eFwd2);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_rd    = '0;
      bus.in_data  = '0;
      bus.drain_en = 1'b0;
      bus.look_rs1 = '0;
      bus.look_rs2 = '0;

      //   name        rst vld rd   data  drn lk1 lk2  wrt rd  data  cnt h1 f1    h2 f2
      add("reset0",     0, 1,  3,  'h7,   1,  0,  0,   0,  0,  0,    0,  0, 0,    0, 0);
      add("reset1",     0, 1,  3,  'h7,   1,  3,  3,   0,  0,  0,    0,  0, 0,    0, 0);
      add("single_q",   1, 1,  10, 'h2,   1,  10, 0,   0,  0,  0,    1,  1, 'h2,  0, 0);
      add("single_w",   1, 0,  0,  0,     1,  10, 0,   1,  10, 'h2,  0,  1, 'h2,  0, 0);
      add("single_done",1, 0,  0,  0,     1,  10, 0,   0,  10, 'h2,  0,  0, 0,    0, 0);
      add("fill1",      1, 1,  1,  'h11,  0,  0,  0,   0,  10, 'h2,  1,  0, 0,    0, 0);
      add("fill2",      1, 1,  2,  'h22,  0,  0,  0,   0,  10, 'h2,  2,  0, 0,    0, 0);
      add("fill3",      1, 1,  3,  'h33,  0,  0,  0,   0,  10, 'h2,  3,  0, 0,    0, 0);
      add("fill4",      1, 1,  4,  'h44,  0,  0,  0,   0,  10, 'h2,  4,  0, 0,    0, 0);
      add("fill5_drop", 1, 1,  5,  'h55,  0,  5,  4,   0,  10, 'h2,  4,  0, 0,    1, 'h44);
      add("drain1",     1, 0,  0,  0,     1,  0,  0,   1,  1,  'h11, 3,  0, 0,    0, 0);
      add("drain2",     1, 0,  0,  0,     1,  0,  0,   1,  2,  'h22, 2,  0, 0,    0, 0);
      add("drain3",     1, 0,  0,  0,     1,  0,  0,   1,  3,  'h33, 1,  0, 0,    0, 0);
      add("drain4",     1, 0,  0,  0,     1,  0,  0,   1,  4,  'h44, 0,  0, 0,    0, 0);
      add("drain_idle", 1, 0,  0,  0,     1,  5,  0,   0,  4,  'h44, 0,  0, 0,    0, 0);
      add("fwd_q1",     1, 1,  11, 'h6,   0,  11, 5,   0,  4,  'h44, 1,  1, 'h6,  0, 0);
      add("fwd_q2",     1, 1,  11, 'h9,   0,  11, 5,   0,  4,  'h44, 2,  1, 'h9,  0, 0);
      add("pushpop1",   1, 1,  7,  'h77,  1,  11, 7,   1,  11, 'h6,  2,  1, 'h9,  1, 'h77);
      add("pushpop2",   1, 1,  8,  'h88,  1,  11, 8,   1,  11, 'h9,  2,  1, 'h9,  1, 'h88);
      add("retire7",    1, 0,  0,  0,     1,  11, 8,   1,  7,  'h77, 1,  0, 0,    1, 'h88);
      add("retire8",    1, 0,  0,  0,     1,  11, 8,   1,  8,  'h88, 0,  0, 0,    1, 'h88);
      add("pre_rst1",   1, 1,  20, 'hA0,  0,  20, 0,   0,  8,  'h88, 1,  1, 'hA0, 0, 0);
      add("pre_rst2",   1, 1,  21, 'hA1,  0,  20, 0,   0,  8,  'h88, 2,  1, 'hA0, 0, 0);
      add("pre_rst3",   1, 1,  22, 'hA2,  0,  20, 22,  0,  8,  'h88, 3,  1, 'hA0, 1, 'hA2);
      add("mid_rst",    0, 0,  0,  0,     1,  20, 22,  0,  0,  0,    0,  0, 0,    0, 0);
      add("post_rst1",  1, 0,  0,  0,     1,  20, 22,  0,  0,  0,    0,  0, 0,    0, 0);
      add("post_rst2",  1, 0,  0,  0,     1,  20, 22,  0,  0,  0,    0,  0, 0,    0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rstN, vecs[i].inValid, vecs[i].inRd, vecs[i].inData,
                       vecs[i].drainEn, vecs[i].look1, vecs[i].look2);
         checkVector(vecs[i]);
      end

      // Streaming: one entry resident, push and pop every edge across pointer wraps.
      applyStimulus(1'b1, 1'b1, ADDR_W'(40), DATA_W'('h100), 1'b1, '0, '0);
      checkOutput("stream_start.wrt",   32'(bus.wrt),   32'(0));
      checkOutput("stream_start.count", 32'(bus.count), 32'(1));
      for (int k = 1; k <= 9; k++) begin
         applyStimulus(1'b1, 1'b1, ADDR_W'(40 + k), DATA_W'('h100 + k), 1'b1, '0, '0);
         checkOutput($sformatf("stream%0d.wrt", k),    32'(bus.wrt),    32'(1));
         checkOutput($sformatf("stream%0d.rd", k),     32'(bus.rd),     32'(40 + k - 1));
         checkOutput($sformatf("stream%0d.dataIn", k), bus.dataIn,      32'('h100 + k - 1));
         checkOutput($sformatf("stream%0d.count", k),  32'(bus.count),  32'(1));
      end
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, '0, '0);
      checkOutput("stream_last.rd",    32'(bus.rd),    32'(49));
      checkOutput("stream_last.empty", 32'(bus.empty), 32'(1));
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, '0, '0);
      checkOutput("stream_idle.wrt",   32'(bus.wrt),   32'(0));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
